out_serializer: RTL and testbench



---
 rtl/out_serializer_pkg.sv | 30 +++
 rtl/out_serializer_byte_fifo.sv | 64 ++++++
 rtl/out_serializer.sv | 126 ++++++++++++
 tb/tb_out_serializer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/out_serializer_pkg.sv
// out_serializer_pkg
// Shared definitions for the output serializer: serial frame constants,
// the transmitter state encoding, and the Control-word bit positions so
// the doOut strobe is taken from the same bit the register stage uses.
package out_serializer_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Control word bit-field positions shared with the register stage.
  localparam int CTRL_WIDTH   = 8;
  localparam int CTRL_LD_A    = 0;
  localparam int CTRL_LD_B    = 1;
  localparam int CTRL_LD_Q    = 2;
  localparam int CTRL_ALU_OP  = 3;
  localparam int CTRL_DO_OUT  = 5;

  function automatic logic ctrl_do_out(input logic [CTRL_WIDTH-1:0] ctrl);
    return ctrl[CTRL_DO_OUT];
  endfunction

endpackage

// File: rtl/out_serializer_byte_fifo.sv
// byte_fifo
// DEPTH x 8 circular buffer with same-cycle push/pop. A push is accepted
// when there is room or when a pop happens on the same edge, so a full
// FIFO being drained can still take a byte.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   push, din      write request and data
//   pop            read request (ignored when empty)
//   dout           head byte (combinational view of storage)
//   full, empty    occupancy flags
//   count          occupancy 0..DEPTH
module byte_fifo
  import out_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Storage has no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_serializer.sv
// out_serializer
// Captures each byte strobed by doOut into a small FIFO and sends it
// LSB-first as an 8N1 asynchronous frame on tx.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   doOut, dbus  push strobe and data byte
//   tx           registered serial line, idles high
//   busy         frame in progress
//   full, empty  FIFO flags
//   count        FIFO occupancy
//   overflow     sticky, set when a push is dropped
//
// state | meaning
// IDLE  | line high; pops head byte when FIFO not empty
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high) for one bit period
module out_serializer
  import out_serializer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     doOut,
  input  logic [7:0]               dbus,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t     state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    fifo_dout;
  logic          pop;
  logic          tc;

  assign pop  = (state == IDLE) && !empty;
  assign tc   = (timer == TW'(CLKS_PER_BIT - 1));
  assign busy = (state != IDLE);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (doOut),
    .din   (dbus),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= STOP_BIT;
      timer    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      overflow <= 1'b0;
    end else begin
      // A full FIFO only drops the byte when nothing leaves this cycle.
      if (doOut && full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          tx <= STOP_BIT;
          if (pop) begin
            shift   <= fifo_dout;
            state   <= START;
            tx      <= START_BIT;
            timer   <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (tc) begin
            timer <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (tc) begin
            timer <= '0;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= STOP_BIT;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (tc) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= STOP_BIT;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_serializer.sv
// tb_out_serializer
// Randomized and directed stimulus against a queue-based reference model.
// The model tracks the FIFO as a queue and the line as "which byte started
// on which cycle"; the expected tx value is derived from elapsed time.
module tb_out_serializer;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          doOut = 1'b0;
  logic [7:0]    dbus = 8'h00;
  logic          tx;
  logic          busy;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  out_serializer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .doOut    (doOut),
    .dbus     (dbus),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q[$];
  bit         m_busy  = 1'b0;
  int         m_start = 0;
  logic [7:0] m_byte  = 8'h00;
  bit         m_ovf   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic model_tx();
    int idx;
    if (!m_busy) return 1'b1;
    idx = (cyc - m_start) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  task automatic step(input logic d_o, input logic [7:0] d, input logic r);
    bit was_busy;
    bit do_pop;
    @(negedge clk);
    doOut = d_o;
    dbus  = d;
    reset = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      was_busy = m_busy;
      do_pop   = !was_busy && (q.size() > 0);
      if (was_busy && (cyc - m_start == 10 * CPB)) m_busy = 1'b0;
      if (do_pop) begin
        m_byte  = q.pop_front();
        m_busy  = 1'b1;
        m_start = cyc;
      end
      if (d_o) begin
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    #1;
    check_val("tx",       32'(tx),       32'(model_tx()));
    check_val("busy",     32'(busy),     32'(m_busy));
    check_val("count",    32'(count),    32'(q.size()));
    check_val("empty",    32'(empty),    32'(q.size() == 0));
    check_val("full",     32'(full),     32'(q.size() == DEPTH));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    bit hit;

    // Reset and idle.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(20);

    // Single byte 0xA5, then past the end of the frame.
    step(1'b1, 8'hA5, 1'b0);
    idle(45);
    check_val("single_done_busy", 32'(busy), 32'(0));

    // Burst of five; first pops at once, rest fill the FIFO.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    check_val("burst_count", 32'(count), 32'(DEPTH));
    check_val("burst_ovf",   32'(overflow), 32'(0));
    // Push while full with a frame in flight: dropped.
    step(1'b1, 8'hFF, 1'b0);
    check_val("ovf_after_ff", 32'(overflow), 32'(1));
    check_val("ovf_count",    32'(count), 32'(DEPTH));
    idle(5 * (10 * CPB + 1) + 10);

    // Full and idle with same-cycle pop: push accepted.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (!m_busy && q.size() == DEPTH) begin
        step(1'b1, 8'h77, 1'b0);
        hit = 1'b1;
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
    end
    check_val("full_pop_ovf",   32'(overflow), 32'(0));
    check_val("full_pop_count", 32'(count),    32'(DEPTH));
    idle(5 * (10 * CPB + 1) + 10);

    // Reset during data bit 3.
    step(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (m_busy && (cyc - m_start) / CPB == 4) break;
      step(1'b0, 8'h00, 1'b0);
    end
    step(1'b1, 8'hEE, 1'b1);
    check_val("midrst_tx",    32'(tx),    32'(1));
    check_val("midrst_busy",  32'(busy),  32'(0));
    check_val("midrst_count", 32'(count), 32'(0));
    step(1'b1, 8'h3C, 1'b0);
    idle(45);

    // Pointer wrap with spaced single pushes.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      idle(44);
      check_val("wrap_count", 32'(count), 32'(0));
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 11) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 499) == 0));
    end
    idle(5 * (10 * CPB + 1) + 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
